regfile_write_scheduler: RTL and testbench

Shares the register file's single write port between the in-order writeback stage and the long-latency mul/div unit in the RISC-V pipeline. Buffers mul/div results and arbitrates them against writeback with bounded starvation. Keeps a scoreboard of registers awaiting mul/div results and drives the decode-stage stall for RAW/WAW hazards on those registers.

---
 rtl/rv_pkg.sv | 15 +
 rtl/md_result_fifo.sv | 66 ++++++
 rtl/regfile_write_scheduler.sv | 149 ++++++++++++++
 tb/tb_regfile_write_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared pipeline definitions: datapath widths and the register-file write
// request payload used by writeback-side blocks.
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREG   = 2 ** REG_AW;

    // One register-file write: destination and value.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wr_req_t;

endpackage

// File: rtl/md_result_fifo.sv
// Small FIFO holding mul/div results until they win the register-file port.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   i_push/i_data  enqueue a result (ignored when full)
//   i_pop          dequeue the head (ignored when empty)
//   o_head         current head entry (valid while o_count != 0)
//   o_count        registered occupancy
module md_result_fifo
    import rv_pkg::*;
#(
    parameter  int unsigned BUF_DEPTH = 2,
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  wr_req_t          i_data,
    input  logic             i_pop,
    output wr_req_t          o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned      PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(BUF_DEPTH - 1);

    wr_req_t          r_mem [BUF_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != CNT_W'(BUF_DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port between writeback and the mul/div unit.
// Buffers mul/div results, arbitrates with bounded starvation of the buffer,
// and keeps a pending-destination scoreboard that drives the decode stall.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   wb_valid/wb_rd/wb_data       writeback request; wb_hold = not accepted
//   md_issue/md_issue_rd         mul/div issue marks destination pending
//   md_valid/md_rd/md_data       mul/div result; md_ready = buffer has room
//   dec_rs1/dec_rs2/dec_rd       decode operands; dec_stall on pending regs
//   rf_we/rf_rd/rf_data          registered register-file write
//   sb_busy                      scoreboard, bit i = xi pending
// XLEN/REG_AW must match rv_pkg, whose request struct the buffer stores.
module regfile_write_scheduler #(
    parameter int unsigned XLEN       = rv_pkg::XLEN,
    parameter int unsigned REG_AW     = rv_pkg::REG_AW,
    parameter int unsigned BUF_DEPTH  = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_valid,
    input  logic [REG_AW-1:0]    wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 wb_hold,
    input  logic                 md_issue,
    input  logic [REG_AW-1:0]    md_issue_rd,
    input  logic                 md_valid,
    input  logic [REG_AW-1:0]    md_rd,
    input  logic [XLEN-1:0]      md_data,
    output logic                 md_ready,
    input  logic [REG_AW-1:0]    dec_rs1,
    input  logic [REG_AW-1:0]    dec_rs2,
    input  logic [REG_AW-1:0]    dec_rd,
    output logic                 dec_stall,
    output logic                 rf_we,
    output logic [REG_AW-1:0]    rf_rd,
    output logic [XLEN-1:0]      rf_data,
    output logic [2**REG_AW-1:0] sb_busy
);

    localparam int unsigned NREG  = 2 ** REG_AW;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);

    rv_pkg::wr_req_t   w_md_req;
    rv_pkg::wr_req_t   w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_push;
    logic              w_nonempty;
    logic              w_force;
    logic              w_wb_win;
    logic              w_buf_win;

    logic [ST_W-1:0]   r_starve;
    logic [ST_W-1:0]   w_starve_nxt;
    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_busy_nxt;
    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_rd;
    logic [XLEN-1:0]   r_rf_data;
    logic              w_rf_we_nxt;
    logic [REG_AW-1:0] w_rf_rd_nxt;
    logic [XLEN-1:0]   w_rf_data_nxt;

    assign w_md_req = '{rd: md_rd, data: md_data};

    md_result_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_md_req),
        .i_pop   (w_buf_win),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Room is judged on the registered count only: no push into a full
    // buffer even when the head leaves on the same edge.
    assign md_ready   = rst && (w_count < CNT_W'(BUF_DEPTH));
    assign w_push     = md_valid && md_ready;
    assign w_nonempty = (w_count != '0);

    // Buffer head is forced through once it has lost STARVE_MAX times.
    assign w_force   = w_nonempty && (r_starve == ST_W'(STARVE_MAX));
    assign w_wb_win  = wb_valid && !w_force;
    assign w_buf_win = w_nonempty && !w_wb_win;
    assign wb_hold   = rst && wb_valid && w_force;

    assign dec_stall = rst && (r_busy[dec_rs1] | r_busy[dec_rs2] | r_busy[dec_rd]);

    assign rf_we   = r_rf_we;
    assign rf_rd   = r_rf_rd;
    assign rf_data = r_rf_data;
    assign sb_busy = r_busy;

    // Next-state: starvation counter, scoreboard, register-file write.
    always_comb begin
        w_starve_nxt  = r_starve;
        w_busy_nxt    = r_busy;
        w_rf_we_nxt   = 1'b0;
        w_rf_rd_nxt   = r_rf_rd;
        w_rf_data_nxt = r_rf_data;

        if (!w_nonempty || w_buf_win) begin
            w_starve_nxt = '0;
        end else if (r_starve != ST_W'(STARVE_MAX)) begin
            w_starve_nxt = r_starve + ST_W'(1);
        end

        // Clear first so a same-edge issue to the popped register wins.
        if (w_buf_win) begin
            w_busy_nxt[w_head.rd] = 1'b0;
        end
        if (md_issue) begin
            w_busy_nxt[md_issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;

        // x0 writes are consumed but never reach the register file.
        if (w_wb_win) begin
            w_rf_we_nxt   = (wb_rd != '0);
            w_rf_rd_nxt   = wb_rd;
            w_rf_data_nxt = wb_data;
        end else if (w_buf_win) begin
            w_rf_we_nxt   = (w_head.rd != '0);
            w_rf_rd_nxt   = w_head.rd;
            w_rf_data_nxt = w_head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve  <= '0;
            r_busy    <= '0;
            r_rf_we   <= 1'b0;
            r_rf_rd   <= '0;
            r_rf_data <= '0;
        end else begin
            r_starve  <= w_starve_nxt;
            r_busy    <= w_busy_nxt;
            r_rf_we   <= w_rf_we_nxt;
            r_rf_rd   <= w_rf_rd_nxt;
            r_rf_data <= w_rf_data_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler with hand-computed expectations.
module tb_regfile_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_hold;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_stall;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [31:0] sb_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_write_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_hold     (wb_hold),
        .md_issue    (md_issue),
        .md_issue_rd (md_issue_rd),
        .md_valid    (md_valid),
        .md_rd       (md_rd),
        .md_data     (md_data),
        .md_ready    (md_ready),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_stall   (dec_stall),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_data     (rf_data),
        .sb_busy     (sb_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [4:0] rd,
                            input logic [31:0] data);
        check_eq({tag, "_we"}, 64'(rf_we), 64'(we));
        check_eq({tag, "_rd"}, 64'(rf_rd), 64'(rd));
        check_eq({tag, "_data"}, 64'(rf_data), 64'(data));
    endtask

    initial begin
        rst = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        md_issue = 1'b0; md_issue_rd = '0; md_valid = 1'b0; md_rd = '0; md_data = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;

        // Reset state
        tick(); tick();
        check_eq("rst_we", 64'(rf_we), 64'd0);
        check_eq("rst_busy", 64'(sb_busy), 64'd0);
        check_eq("rst_ready", 64'(md_ready), 64'd0);
        check_eq("rst_hold", 64'(wb_hold), 64'd0);
        check_eq("rst_stall", 64'(dec_stall), 64'd0);
        rst = 1'b1;
        #1;
        check_eq("rel_ready", 64'(md_ready), 64'd1);

        // Single mul/div op
        md_issue = 1'b1; md_issue_rd = 5'd5;
        tick();
        md_issue = 1'b0;
        check_eq("t1_busy", 64'(sb_busy), 64'h20);
        dec_rs1 = 5'd5;
        #1;
        check_eq("t1_stall", 64'(dec_stall), 64'd1);
        md_valid = 1'b1; md_rd = 5'd5; md_data = 32'h1234;
        tick();
        md_valid = 1'b0;
        check_eq("t1_we_early", 64'(rf_we), 64'd0);
        tick();
        check_rf("t1_wr", 1'b1, 5'd5, 32'h1234);
        check_eq("t1_busy_clr", 64'(sb_busy), 64'd0);
        check_eq("t1_stall_clr", 64'(dec_stall), 64'd0);
        dec_rs1 = '0;
        tick();
        check_eq("t1_we_done", 64'(rf_we), 64'd0);

        // Starvation under continuous writeback
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hA0;
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h77;
        tick();
        md_valid = 1'b0;
        check_rf("t2_wb0", 1'b1, 5'd3, 32'hA0);
        for (int k = 1; k <= 4; k++) begin
            wb_data = 32'hA0 + 32'(k);
            #1;
            check_eq("t2_nohold", 64'(wb_hold), 64'd0);
            tick();
            check_rf("t2_wb", 1'b1, 5'd3, 32'hA0 + 32'(k));
        end
        wb_data = 32'hA5;
        #1;
        check_eq("t2_hold", 64'(wb_hold), 64'd1);
        tick();
        check_rf("t2_forced", 1'b1, 5'd7, 32'h77);
        check_eq("t2_hold_drop", 64'(wb_hold), 64'd0);
        tick();
        check_rf("t2_held_wb", 1'b1, 5'd3, 32'hA5);
        wb_valid = 1'b0;
        tick();

        // Full buffer, no push-through-pop
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h200;
        md_valid = 1'b1; md_rd = 5'd10; md_data = 32'hB10;
        tick();
        md_rd = 5'd11; md_data = 32'hB11;
        #1;
        check_eq("t3_ready1", 64'(md_ready), 64'd1);
        tick();
        md_rd = 5'd12; md_data = 32'hB12;
        #1;
        check_eq("t3_full", 64'(md_ready), 64'd0);
        tick(); tick();
        check_eq("t3_full_f3", 64'(md_ready), 64'd0);
        check_eq("t3_nohold_f3", 64'(wb_hold), 64'd0);
        tick();
        check_eq("t3_full_pop", 64'(md_ready), 64'd0);
        check_eq("t3_hold_f4", 64'(wb_hold), 64'd1);
        tick();
        check_rf("t3_pop10", 1'b1, 5'd10, 32'hB10);
        check_eq("t3_ready_after", 64'(md_ready), 64'd1);
        check_eq("t3_nohold_f5", 64'(wb_hold), 64'd0);
        tick();
        check_rf("t3_wb", 1'b1, 5'd2, 32'h200);
        check_eq("t3_full_again", 64'(md_ready), 64'd0);
        md_valid = 1'b0; wb_valid = 1'b0;
        tick();
        check_rf("t3_pop11", 1'b1, 5'd11, 32'hB11);
        tick();
        check_rf("t3_pop12", 1'b1, 5'd12, 32'hB12);
        tick();
        check_eq("t3_idle", 64'(rf_we), 64'd0);

        // x0 handling
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h5;
        md_issue = 1'b1; md_issue_rd = 5'd0;
        tick();
        check_eq("t4_wb_x0", 64'(rf_we), 64'd0);
        check_eq("t4_busy_x0", 64'(sb_busy), 64'd0);
        wb_valid = 1'b0; md_issue = 1'b0;
        md_valid = 1'b1; md_rd = 5'd0; md_data = 32'hC0;
        tick();
        md_rd = 5'd8; md_data = 32'hC8;
        tick();
        md_valid = 1'b0;
        check_eq("t4_md_x0", 64'(rf_we), 64'd0);
        tick();
        check_rf("t4_after_x0", 1'b1, 5'd8, 32'hC8);
        tick();

        // Same-edge set and clear
        md_issue = 1'b1; md_issue_rd = 5'd9;
        tick();
        md_issue = 1'b0;
        check_eq("t5_busy", 64'(sb_busy), 64'h200);
        md_valid = 1'b1; md_rd = 5'd9; md_data = 32'hD9;
        tick();
        md_valid = 1'b0;
        md_issue = 1'b1; md_issue_rd = 5'd9;
        tick();
        md_issue = 1'b0;
        check_rf("t5_pop", 1'b1, 5'd9, 32'hD9);
        check_eq("t5_set_wins", 64'(sb_busy), 64'h200);
        md_valid = 1'b1; md_rd = 5'd9; md_data = 32'hD9B;
        tick();
        md_valid = 1'b0;
        tick();
        check_eq("t5_cleared", 64'(sb_busy), 64'd0);

        // Reset mid-operation
        md_issue = 1'b1; md_issue_rd = 5'd4;
        tick();
        md_issue_rd = 5'd6;
        tick();
        md_issue = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hE1;
        md_valid = 1'b1; md_rd = 5'd4; md_data = 32'hE4;
        tick();
        md_rd = 5'd6; md_data = 32'hE6;
        tick();
        md_valid = 1'b0;
        check_eq("t6_full", 64'(md_ready), 64'd0);
        check_eq("t6_busy", 64'(sb_busy), 64'h50);
        dec_rs1 = 5'd4;
        #1;
        check_eq("t6_stall", 64'(dec_stall), 64'd1);
        rst = 1'b0;
        #1;
        check_eq("t6_rst_ready", 64'(md_ready), 64'd0);
        check_eq("t6_rst_stall", 64'(dec_stall), 64'd0);
        check_eq("t6_rst_hold", 64'(wb_hold), 64'd0);
        tick();
        check_eq("t6_rst_we", 64'(rf_we), 64'd0);
        check_eq("t6_rst_busy", 64'(sb_busy), 64'd0);
        check_eq("t6_rst_ready2", 64'(md_ready), 64'd0);
        rst = 1'b1; wb_valid = 1'b0; dec_rs1 = '0;
        #1;
        check_eq("t6_rel_ready", 64'(md_ready), 64'd1);
        tick();
        check_eq("t6_drained", 64'(rf_we), 64'd0);
        tick();
        check_eq("t6_drained2", 64'(rf_we), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
